mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline stage directly downstream of the ALU: accepts the EX-stage result (ALU output plus control), performs `lw`/`sw` against a word-addressed data memory through a req/ack handshake, and registers the MEM/WB outputs that feed register write-back. While a memory access is outstanding, the stage back-pressures EX through `in_ready`. Non-memory instructions pass straight through with one cycle of latency.

## Interface
- `ADDR_W`, 10 — word-address width of the data memory. Valid addresses are `0 .. 2^ADDR_W-1`.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `in_valid` input 1 — EX presents an instruction this cycle.
- `in_ready` output 1 — stage can accept an instruction. A transfer occurs on an edge where `in_valid & in_ready`.
- `in_opcode` input 6 — MIPS opcode: `6'b100011` is `lw`, `6'b101011` is `sw`; all other values are non-memory.
- `in_alu_result` input 32 — ALU result. For `lw`/`sw` this is already a word address; no further shifting is applied.
- `in_store_data` input 32 — rt value for `sw`.
- `in_dest_reg` input 5 — write-back register index.
- `in_reg_write` input 1 — instruction writes a register.
- `mem_req` output 1 — memory request.
- `mem_we` output 1 — request is a write.
- `mem_addr` output ADDR_W — word address.
- `mem_wdata` output 32 — write data.
- `mem_ack` input 1 — memory completes the request this cycle. `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32 — read data.
- `wb_valid` output 1 — one-cycle pulse; the `wb_*` outputs are valid.
- `wb_reg_write` output 1 — write-back enable.
- `wb_dest_reg` output 5 — write-back register.
- `wb_data` output 32 — write-back value.
- `wb_addr_err` output 1 — the pulsed instruction was a `lw`/`sw` with an out-of-range address.

## Operation
- **FSM states:** IDLE and WAIT.
  - `in_ready = (state == IDLE)`. This is combinational from the state register only.
- **IDLE, non-memory instruction accepted:**
  - Next edge: `wb_valid=1`, `wb_data=in_alu_result`, `wb_dest_reg=in_dest_reg`.
  - `wb_reg_write = in_reg_write & (in_dest_reg != 0)`.
  - State stays IDLE.
- **IDLE, `lw`/`sw` accepted, address in range (`in_alu_result[31:ADDR_W] == 0`):**
  - Latch the address, store data, destination and type.
  - Go to WAIT.
  - `mem_req=1` from the next cycle.
- **IDLE, `lw`/`sw` accepted, address out of range** (any upper bit set, including negative values):
  - No memory request is issued.
  - Next edge: `wb_valid=1`, `wb_addr_err=1`, `wb_reg_write=0`, `wb_data=0`.
  - State stays IDLE.
- **WAIT:**
  - `mem_req=1`. `mem_we`, `mem_addr` and `mem_wdata` are held stable (registered) until the ack.
  - On an edge with `mem_ack=1`, go to IDLE.
  - On that same edge, `wb_valid=1`. For `lw`: `wb_data=mem_rdata`, `wb_reg_write = (dest != 0)`. For `sw`: `wb_reg_write=0`, `wb_data=0`.
- **`mem_ack` outside WAIT:** ignored; no state change, no `wb_valid`.
- **`wb_*` register behaviour:** `wb_valid` and `wb_addr_err` are 1 only in the cycle after the completing edge. The other `wb_*` outputs hold their last values when `wb_valid=0`.
- **`mem_we`/`mem_addr`/`mem_wdata` when `mem_req=0`:** these hold their last values.
- **Reset (`rst_n=0` at an edge):** state IDLE.
  - `mem_req`, `mem_we`, `wb_valid`, `wb_reg_write` and `wb_addr_err` go to 0.
  - `mem_addr`, `mem_wdata`, `wb_dest_reg` and `wb_data` go to 0.
  - Reset during WAIT abandons the access. An ack arriving after reset is ignored.

## Timing
- **Non-memory instruction:**
  - Latency: 1 cycle from the accept edge to `wb_valid`.
  - Throughput: 1 per cycle (`in_ready` stays high).
- **Memory instruction:**
  - `mem_req` rises in the cycle after the accept edge.
  - The earliest ack is in that same cycle, which gives `wb_valid` 2 cycles after accept.
  - `in_ready` is low from the accept edge through the ack edge.
  - The next instruction can be accepted on the first edge after the ack edge.
- **Ack sampling:** `mem_ack` is only sampled in WAIT. An ack that is held high for multiple cycles completes exactly one request.
- **Output registration:** every output except `in_ready` is a register output.

## Test plan
- **Reset mid-access:**
  - Accept `sw` at address 5.
  - Assert `rst_n=0` during WAIT, before the ack.
  - Release reset, then drive `mem_ack=1`.
  - Required: after the reset edge, `mem_req=0` and `in_ready=1`; no `wb_valid`; the late ack is ignored.
- **Pass-through:**
  - Drive back-to-back `addi`-type instructions with results 7, 8, 9 and dest regs 3, 4, 0.
  - Required: `wb_valid` pulses on 3 consecutive cycles with `wb_data` 7, 8, 9.
  - Required: `wb_reg_write` is 1, 1, 0 (the third because dest is `$0`).
  - Required: `in_ready` never drops.
- **`lw`, zero-wait memory:**
  - `lw` at address 0x12 with dest 8; `mem_ack=1` in the first request cycle with `mem_rdata=0xDEADBEEF`.
  - Required: `mem_addr=0x12` and `mem_we=0`.
  - Required: `wb_valid` 2 cycles after accept, with `wb_data=0xDEADBEEF`, `wb_dest_reg=8` and `wb_reg_write=1`.
- **`sw` with 3-cycle ack delay:**
  - `sw` at address 0x3FF with data 0x1234.
  - Required: `mem_req`, `mem_we=1`, `mem_addr=0x3FF` and `mem_wdata=0x1234` are stable for 3 cycles.
  - Required: `in_ready=0` throughout; `in_valid` held high is not accepted.
  - Required: after the ack, a single `wb_valid` with `wb_reg_write=0`.
- **Out-of-range address:**
  - `lw` at address 0x400, then `sw` at address 0xFFFFFFFF.
  - Required: no `mem_req` for either.
  - Required: each produces `wb_valid` with `wb_addr_err=1`, `wb_reg_write=0` and `wb_data=0`, one cycle after accept.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: lw/sw against word-addressed data memory over req/ack, registered MEM/WB outputs.
// Non-memory ops pass through in 1 cycle; memory ops hold off EX (in_ready low) until the ack edge.
module mem_access_stage #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_dest_reg,
  input  logic              in_reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dest_reg,
  output logic [31:0]       wb_data,
  output logic              wb_addr_err
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state;
  logic [4:0] pend_dest;
  logic       is_mem;
  logic       in_range;

  assign in_ready = (state == IDLE);
  assign is_mem   = (in_opcode == OP_LW) || (in_opcode == OP_SW);
  // Any address bit above the memory size (including sign bits) is a fault.
  assign in_range = (in_alu_result[31:ADDR_W] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_dest    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest_reg  <= '0;
      wb_data      <= '0;
      wb_addr_err  <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mem && in_range) begin
              state     <= WAIT;
              mem_req   <= 1'b1;
              mem_we    <= (in_opcode == OP_SW);
              mem_addr  <= in_alu_result[ADDR_W-1:0];
              mem_wdata <= in_store_data;
              pend_dest <= in_dest_reg;
            end else if (is_mem) begin
              wb_valid     <= 1'b1;
              wb_addr_err  <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_dest_reg  <= in_dest_reg;
              wb_data      <= '0;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= in_reg_write && (in_dest_reg != 5'd0);
              wb_dest_reg  <= in_dest_reg;
              wb_data      <= in_alu_result;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_dest_reg <= pend_dest;
            // mem_we still records whether the pending access is a store.
            if (mem_we) begin
              wb_reg_write <= 1'b0;
              wb_data      <= '0;
            end else begin
              wb_reg_write <= (pend_dest != 5'd0);
              wb_data      <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle vector table plus hand sequences for waits and reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest_reg;
  logic        in_reg_write;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_data;
  logic        wb_addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_dest_reg(in_dest_reg), .in_reg_write(in_reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest_reg(wb_dest_reg),
    .wb_data(wb_data), .wb_addr_err(wb_addr_err)
  );

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        ack;
    logic [31:0] rdata;
    logic        e_wbv;
    logic        e_wbrw;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_req;
    logic        e_rdy;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] dest, input logic rw,
                       input logic ack, input logic [31:0] rdata);
    in_valid      = v;
    in_opcode     = op;
    in_alu_result = alu;
    in_store_data = sd;
    in_dest_reg   = dest;
    in_reg_write  = rw;
    mem_ack       = ack;
    mem_rdata     = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         v  op    alu            sd          dest rw ack rdata         wbv rw dest data          err req rdy we addr    wdata
    vecs[0]  = '{1, ADDI, 32'd7,        32'd0,      5'd3, 1, 0, 32'd0,        1, 1, 5'd3, 32'd7,        0, 0, 1, 0, 10'h000, 32'd0};
    vecs[1]  = '{1, ADDI, 32'd8,        32'd0,      5'd4, 1, 0, 32'd0,        1, 1, 5'd4, 32'd8,        0, 0, 1, 0, 10'h000, 32'd0};
    vecs[2]  = '{1, ADDI, 32'd9,        32'd0,      5'd0, 1, 0, 32'd0,        1, 0, 5'd0, 32'd9,        0, 0, 1, 0, 10'h000, 32'd0};
    vecs[3]  = '{0, ADDI, 32'd0,        32'd0,      5'd0, 0, 0, 32'd0,        0, 0, 5'd0, 32'd9,        0, 0, 1, 0, 10'h000, 32'd0};
    vecs[4]  = '{1, LW,   32'h12,       32'd0,      5'd8, 1, 0, 32'd0,        0, 0, 5'd0, 32'd9,        0, 1, 0, 0, 10'h012, 32'd0};
    vecs[5]  = '{0, ADDI, 32'd0,        32'd0,      5'd0, 0, 1, 32'hDEADBEEF, 1, 1, 5'd8, 32'hDEADBEEF, 0, 0, 1, 0, 10'h012, 32'd0};
    vecs[6]  = '{1, LW,   32'h400,      32'd0,      5'd5, 1, 0, 32'd0,        1, 0, 5'd5, 32'd0,        1, 0, 1, 0, 10'h012, 32'd0};
    vecs[7]  = '{1, SW,   32'hFFFFFFFF, 32'hAA,     5'd6, 0, 0, 32'd0,        1, 0, 5'd6, 32'd0,        1, 0, 1, 0, 10'h012, 32'd0};
    vecs[8]  = '{0, ADDI, 32'd0,        32'd0,      5'd0, 0, 0, 32'd0,        0, 0, 5'd6, 32'd0,        0, 0, 1, 0, 10'h012, 32'd0};
    vecs[9]  = '{0, ADDI, 32'd0,        32'd0,      5'd0, 0, 1, 32'h99,       0, 0, 5'd6, 32'd0,        0, 0, 1, 0, 10'h012, 32'd0};
    vecs[10] = '{1, LW,   32'h3,        32'd0,      5'd0, 1, 0, 32'd0,        0, 0, 5'd6, 32'd0,        0, 1, 0, 0, 10'h003, 32'd0};
    vecs[11] = '{0, ADDI, 32'd0,        32'd0,      5'd0, 0, 1, 32'h55,       1, 0, 5'd0, 32'h55,       0, 0, 1, 0, 10'h003, 32'd0};

    rst_n = 1'b0;
    drive(0, ADDI, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_reg_write", wb_reg_write, 0);
    chk("rst wb_dest_reg", wb_dest_reg, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_addr_err", wb_addr_err, 0);
    rst_n = 1'b1;

    // Each row: inputs before an edge, expected registered outputs after it.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].alu, vecs[i].sd, vecs[i].dest,
            vecs[i].rw, vecs[i].ack, vecs[i].rdata);
      tick();
      chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].e_wbv);
      chk($sformatf("v%0d wb_reg_write", i), wb_reg_write, vecs[i].e_wbrw);
      chk($sformatf("v%0d wb_dest_reg", i), wb_dest_reg, vecs[i].e_dest);
      chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("v%0d wb_addr_err", i), wb_addr_err, vecs[i].e_err);
      chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_req);
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
    end

    // sw with three request cycles; a competing instruction stays valid meanwhile.
    drive(1, SW, 32'h3FF, 32'h1234, 5'd2, 0, 0, 0);
    tick();
    drive(1, ADDI, 32'h77, 0, 5'd9, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sw c%0d mem_req", c), mem_req, 1);
      chk($sformatf("sw c%0d mem_we", c), mem_we, 1);
      chk($sformatf("sw c%0d mem_addr", c), mem_addr, 10'h3FF);
      chk($sformatf("sw c%0d mem_wdata", c), mem_wdata, 32'h1234);
      chk($sformatf("sw c%0d in_ready", c), in_ready, 0);
      chk($sformatf("sw c%0d wb_valid", c), wb_valid, 0);
      if (c == 2) drive(0, ADDI, 0, 0, 0, 0, 1, 32'hFFFF);
      tick();
    end
    chk("sw ack wb_valid", wb_valid, 1);
    chk("sw ack wb_reg_write", wb_reg_write, 0);
    chk("sw ack wb_data", wb_data, 0);
    chk("sw ack wb_dest_reg", wb_dest_reg, 2);
    chk("sw ack mem_req", mem_req, 0);
    chk("sw ack in_ready", in_ready, 1);
    tick();  // ack still high: must not complete anything else
    chk("sw held-ack wb_valid", wb_valid, 0);
    chk("sw held-ack mem_req", mem_req, 0);
    chk("sw held-ack wb_dest_reg", wb_dest_reg, 2);

    // Reset during WAIT abandons the store; a late ack is ignored.
    drive(1, SW, 32'h5, 32'hCAFE, 5'd1, 0, 0, 0);
    tick();
    chk("rmid mem_req", mem_req, 1);
    chk("rmid mem_addr", mem_addr, 10'h005);
    drive(0, ADDI, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("rmid rst mem_req", mem_req, 0);
    chk("rmid rst in_ready", in_ready, 1);
    chk("rmid rst wb_valid", wb_valid, 0);
    chk("rmid rst mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111;
    tick();
    chk("late ack wb_valid", wb_valid, 0);
    chk("late ack mem_req", mem_req, 0);
    chk("late ack in_ready", in_ready, 1);
    tick();
    chk("late ack2 wb_valid", wb_valid, 0);
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
